// File: rtl/block_identify.sv
// Identifies a 4x4 piece matrix by scanning the 20-entry shape table, one entry per cycle.
// Optional BLOCK_ID_ALLMATCH_EN: scan every entry and also report match_mask/match_count.
module block_identify #(
    parameter int NUM_BLOCKS = 5,
    parameter int NUM_ROT    = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [15:0] block_matrix,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [9:0]  block_num,
    output logic [9:0]  rotate
`ifdef BLOCK_ID_ALLMATCH_EN
    ,
    output logic [19:0] match_mask,
    output logic [4:0]  match_count
`endif
);

    // Handshake: start is sampled only in IDLE; busy is high for the whole scan;
    // done pulses for one cycle with found/block_num/rotate already valid.
    localparam logic [4:0] LAST_IDX = 5'(NUM_BLOCKS * NUM_ROT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  idx;
    logic [15:0] matrix_q;
    logic        hit;
    logic        last;

    function automatic logic [15:0] shape_at(input logic [4:0] i);
        logic [15:0] s;
        case (i)
            5'd0:  s = 16'h4444;
            5'd1:  s = 16'h0F00;
            5'd2:  s = 16'h2222;
            5'd3:  s = 16'h00F0;
            5'd4, 5'd5, 5'd6, 5'd7:   s = 16'h0660;
            5'd8, 5'd9, 5'd10, 5'd11: s = 16'h0C60;
            5'd12: s = 16'h4C40;
            5'd13: s = 16'h2700;
            5'd14: s = 16'h0232;
            5'd15: s = 16'h00E4;
            5'd16: s = 16'h888C;
            5'd17: s = 16'hF800;
            5'd18: s = 16'h3111;
            5'd19: s = 16'h001F;
            default: s = 16'h0000;
        endcase
        return s;
    endfunction

    assign hit  = (shape_at(idx) == matrix_q);
    assign last = (idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_SCAN;
`ifdef BLOCK_ID_ALLMATCH_EN
            S_SCAN: if (last) state_nxt = S_DONE;
`else
            S_SCAN: if (hit || last) state_nxt = S_DONE;
`endif
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == S_SCAN);
        done = (state == S_DONE);
    end

    // Search datapath; result registers hold until the next accepted start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx       <= 5'd0;
            matrix_q  <= 16'h0000;
            found     <= 1'b0;
            block_num <= 10'd0;
            rotate    <= 10'd0;
`ifdef BLOCK_ID_ALLMATCH_EN
            match_mask  <= 20'd0;
            match_count <= 5'd0;
`endif
        end else begin
            if (state == S_IDLE && start) begin
                idx       <= 5'd0;
                matrix_q  <= block_matrix;
                found     <= 1'b0;
                block_num <= 10'd0;
                rotate    <= 10'd0;
`ifdef BLOCK_ID_ALLMATCH_EN
                match_mask  <= 20'd0;
                match_count <= 5'd0;
`endif
            end else if (state == S_SCAN) begin
                // Lowest index wins, so duplicate shapes report rotation 0.
                if (hit && !found) begin
                    found     <= 1'b1;
                    block_num <= {7'd0, idx[4:2]};
                    rotate    <= {8'd0, idx[1:0]};
                end
`ifdef BLOCK_ID_ALLMATCH_EN
                if (hit) begin
                    match_mask[idx] <= 1'b1;
                    match_count     <= match_count + 5'd1;
                end
`endif
                if (!last) idx <= idx + 5'd1;
            end
        end
    end

endmodule
